// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, JAL opcode, fetch-buffer entry
// and the J-type immediate decoder used by the optional JAL predictor.
package pipeline_pkg;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam logic [6:0]  OPC_JAL  = 7'b1101111;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

   // Sign-extended J-immediate {imm[20], imm[10:1], imm[11], imm[19:12]} << 1
   function automatic logic [31:0] jal_offset(input logic [31:0] inst);
      return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction

endpackage

// File: rtl/fetch_buf.sv
// Circular FIFO of fetched {pc, inst} entries; clear has priority over
// push/pop, and push into a full buffer is allowed when a pop frees a slot.
module fetch_buf
   import pipeline_pkg::*;
#(
   parameter  int DEPTH = 2,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_clear,
   input  logic               i_push,
   input  logic               i_pop,
   input  fetch_entry_t       i_data,
   output fetch_entry_t       o_head,
   output logic               o_full,
   output logic               o_empty,
   output logic [CNT_W-1:0]   o_count
);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_push;
   logic w_do_pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_clear) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
         unique case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // NOTE: storage has no reset; r_count gates every read, so stale slots are never observed.
   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_clear) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited request issue, in-order response
// capture into fetch_buf, redirect flush. Optional JAL predecode under
// macro FETCH_JAL_PREDICT_EN.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   output logic        o_valid,
   output logic [31:0] o_pc,
   output logic [31:0] o_inst
);

   localparam int          CNT_W       = $clog2(BUF_DEPTH + 1);
   localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

   if (BUF_DEPTH < 2 || BUF_DEPTH > 4) begin : g_depth_check
      $error("fetch_stage: BUF_DEPTH must be in 2..4");
   end

   logic [31:0]      r_pc;
   logic [31:0]      r_rsp_pc;
   logic [CNT_W-1:0] r_outstanding;
   logic [CNT_W-1:0] r_discard;

   fetch_entry_t     w_buf_head;
   fetch_entry_t     w_push_entry;
   logic             w_buf_full;
   logic             w_buf_empty;
   logic [CNT_W-1:0] w_buf_count;
   logic [CNT_W-1:0] w_inflight;
   logic [CNT_W-1:0] w_out_next;
   logic [31:0]      w_redirect_pc;
   logic             w_rsp;
   logic             w_push;
   logic             w_pop;
   logic             w_req;
   logic             w_accept;
   logic             w_unused;

`ifdef FETCH_JAL_PREDICT_EN
   logic             w_jal_taken;
   logic [31:0]      w_jal_target;
`endif

   assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};
   assign w_push_entry  = '{pc: r_rsp_pc, inst: i_imem_rdata};
   assign w_unused      = ^{i_redirect_pc[1:0], w_buf_full};

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_rsp      = i_imem_rvalid && (r_outstanding != '0);
      w_push     = w_rsp && !i_redirect && (r_discard == '0);
      w_pop      = !w_buf_empty && !i_stall && !i_redirect;
      // A head leaving this cycle frees its slot for a new request.
      w_inflight = r_outstanding + w_buf_count - CNT_W'(w_pop);
      w_req      = i_reset && !i_redirect && (w_inflight < CNT_W'(BUF_DEPTH));
      w_accept   = w_req && i_imem_gnt;
      w_out_next = r_outstanding;
      unique case ({w_accept, w_rsp})
         2'b10:   w_out_next = r_outstanding + CNT_W'(1);
         2'b01:   w_out_next = r_outstanding - CNT_W'(1);
         default: ;
      endcase
   end

`ifdef FETCH_JAL_PREDICT_EN
   always_comb begin
      w_jal_taken  = w_push && (i_imem_rdata[6:0] == OPC_JAL);
      w_jal_target = r_rsp_pc + jal_offset(i_imem_rdata);
      w_jal_target[1:0] = 2'b00;
   end
`endif

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_pc          <= RESET_PC_AL;
         r_rsp_pc      <= RESET_PC_AL;
         r_outstanding <= '0;
         r_discard     <= '0;
      end else begin
         r_outstanding <= w_out_next;
         if (i_redirect) begin
            r_pc      <= w_redirect_pc;
            r_rsp_pc  <= w_redirect_pc;
            r_discard <= r_outstanding - CNT_W'(w_rsp);
         end
`ifdef FETCH_JAL_PREDICT_EN
         else if (w_jal_taken) begin
            // Everything still in flight, including a same-cycle grant, is wrong-path.
            r_pc      <= w_jal_target;
            r_rsp_pc  <= w_jal_target;
            r_discard <= w_out_next;
         end
`endif
         else begin
            if (w_accept) r_pc <= r_pc + 32'd4;
            if (w_push)   r_rsp_pc <= r_rsp_pc + 32'd4;
            if (w_rsp && (r_discard != '0)) r_discard <= r_discard - CNT_W'(1);
         end
      end
   end

   fetch_buf #(
      .DEPTH (BUF_DEPTH)
   ) u_buf (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clear (i_redirect),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_data  (w_push_entry),
      .o_head  (w_buf_head),
      .o_full  (w_buf_full),
      .o_empty (w_buf_empty),
      .o_count (w_buf_count)
   );

   assign o_imem_req  = w_req;
   assign o_imem_addr = r_pc;
   assign o_valid     = !w_buf_empty;
   assign o_pc        = o_valid ? w_buf_head.pc   : 32'h0;
   assign o_inst      = o_valid ? w_buf_head.inst : NOP_INST;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an in-order, 1-cycle-latency memory model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        i_reset;
   logic        i_stall;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_imem_req;
   logic [31:0] o_imem_addr;
   logic        i_imem_gnt;
   logic        i_imem_rvalid;
   logic [31:0] i_imem_rdata;
   logic        o_valid;
   logic [31:0] o_pc;
   logic [31:0] o_inst;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] pending[$];
   bit          mem_auto = 1'b0;
   bit          jal_mode = 1'b0;
   bit          last_acc;
   logic [31:0] last_acc_addr;
   int          n_acc;

   always #5 clk = ~clk;

   fetch_stage #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .i_clk         (clk),
      .i_reset       (i_reset),
      .i_stall       (i_stall),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_imem_req    (o_imem_req),
      .o_imem_addr   (o_imem_addr),
      .i_imem_gnt    (i_imem_gnt),
      .i_imem_rvalid (i_imem_rvalid),
      .i_imem_rdata  (i_imem_rdata),
      .o_valid       (o_valid),
      .o_pc          (o_pc),
      .o_inst        (o_inst)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      if (jal_mode && a == 32'h20) return 32'h1000_006F;  // jal x0, +0x100
      return {a[23:0], 8'h13};
   endfunction

   task automatic mem_drive();
      if (mem_auto && pending.size() > 0) begin
         i_imem_rvalid = 1'b1;
         i_imem_rdata  = inst_of(pending[0]);
      end else begin
         i_imem_rvalid = 1'b0;
         i_imem_rdata  = 32'h0;
      end
   endtask

   // One clock: sample handshake mid-cycle, update memory model at the edge.
   task automatic tick();
      bit          acc;
      bit          rsp;
      logic [31:0] a;
      @(negedge clk);
      acc = o_imem_req && i_imem_gnt;
      a   = o_imem_addr;
      rsp = i_imem_rvalid;
      @(posedge clk);
      if (rsp && pending.size() > 0) void'(pending.pop_front());
      if (acc) pending.push_back(a);
      last_acc = acc;
      if (acc) last_acc_addr = a;
      #1;
      mem_drive();
   endtask

   task automatic do_reset();
      i_reset    = 1'b0;
      i_redirect = 1'b0;
      i_stall    = 1'b0;
      i_imem_gnt = 1'b0;
      mem_auto   = 1'b0;
      pending.delete();
      mem_drive();
      tick();
      tick();
      i_reset = 1'b1;
   endtask

   task automatic redirect_to(input logic [31:0] target);
      i_redirect    = 1'b1;
      i_redirect_pc = target;
      tick();
      i_redirect    = 1'b0;
   endtask

   initial begin
      i_reset = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = 32'h0;
      i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = 32'h0;
      #1;
      check("rst_req",   32'(o_imem_req), 32'h0);
      check("rst_valid", 32'(o_valid),    32'h0);
      check("rst_pc",    o_pc,            32'h0);
      check("rst_inst",  o_inst,          32'h13);
      check("rst_addr",  o_imem_addr,     32'h0);
      tick(); tick();
      i_reset = 1'b1;

      // Streaming: back-to-back issue, valid held
      i_imem_gnt = 1'b1; mem_auto = 1'b1;
      tick(); check("seq_acc0", last_acc_addr, 32'h0); check("seq_v0", 32'(o_valid), 32'h0);
      tick(); check("seq_acc1", last_acc_addr, 32'h4); check("seq_pc0", o_pc, 32'h0);
      check("seq_inst0", o_inst, 32'h0000_0013); check("seq_v1", 32'(o_valid), 32'h1);
      tick(); check("seq_acc2", last_acc_addr, 32'h8); check("seq_pc1", o_pc, 32'h4);
      check("seq_v2", 32'(o_valid), 32'h1);
      tick(); check("seq_pc2", o_pc, 32'h8); check("seq_v3", 32'(o_valid), 32'h1);

      // Stall for 5 cycles: head stable, credit exhausted, nothing lost
      i_stall = 1'b1; n_acc = 0;
      repeat (5) begin
         tick();
         if (last_acc) n_acc++;
         check("stall_pc", o_pc, 32'h8);
         check("stall_inst", o_inst, 32'h0000_0813);
      end
      check("stall_nacc", 32'(n_acc), 32'h0);
      check("stall_req", 32'(o_imem_req), 32'h0);
      i_stall = 1'b0;
      tick(); check("rel_acc", last_acc_addr, 32'h10); check("rel_pc0", o_pc, 32'hC);
      tick(); check("rel_pc1", o_pc, 32'h10);
      tick(); check("rel_pc2", o_pc, 32'h14);

      // Redirect with two outstanding, same cycle as the first response
      do_reset();
      redirect_to(32'h10);
      check("rd_addr0", o_imem_addr, 32'h10);
      i_imem_gnt = 1'b1;
      tick(); tick();
      i_imem_gnt = 1'b0;
      check("rd_full_req", 32'(o_imem_req), 32'h0);
      check("rd_addr1", o_imem_addr, 32'h18);
      mem_auto = 1'b1; mem_drive();
      redirect_to(32'h200);
      i_imem_gnt = 1'b1;
      check("rd_addr2", o_imem_addr, 32'h200);
      check("rd_v0", 32'(o_valid), 32'h0);
      tick(); check("rd_v1", 32'(o_valid), 32'h0); check("rd_acc", last_acc_addr, 32'h200);
      tick(); check("rd_v2", 32'(o_valid), 32'h1); check("rd_pc", o_pc, 32'h200);
      check("rd_inst", o_inst, 32'h0002_0013);
      i_imem_gnt = 1'b0;

      // Grant withheld: address held, single delivery afterwards
      do_reset();
      redirect_to(32'h40);
      mem_auto = 1'b1;
      repeat (3) begin
         tick();
         check("gnt_addr", o_imem_addr, 32'h40);
         check("gnt_req", 32'(o_imem_req), 32'h1);
         check("gnt_v", 32'(o_valid), 32'h0);
      end
      i_imem_gnt = 1'b1; tick(); i_imem_gnt = 1'b0;
      tick(); check("gnt_v1", 32'(o_valid), 32'h1); check("gnt_pc", o_pc, 32'h40);
      check("gnt_inst", o_inst, 32'h0000_4013);
      tick(); check("gnt_once", 32'(o_valid), 32'h0);

      // Reset mid-transaction: stale responses ignored
      do_reset();
      i_imem_gnt = 1'b1;
      tick(); tick();
      i_imem_gnt = 1'b0;
      i_reset = 1'b0;
      #1;
      check("mid_rst_req", 32'(o_imem_req), 32'h0);
      check("mid_rst_v", 32'(o_valid), 32'h0);
      tick();
      i_reset = 1'b1; mem_auto = 1'b1; mem_drive();
      tick(); check("stale_v0", 32'(o_valid), 32'h0);
      tick(); check("stale_v1", 32'(o_valid), 32'h0);
      check("stale_addr", o_imem_addr, 32'h0);
      i_imem_gnt = 1'b1; tick(); i_imem_gnt = 1'b0;
      tick(); check("fresh_v", 32'(o_valid), 32'h1); check("fresh_pc", o_pc, 32'h0);
      check("fresh_inst", o_inst, 32'h0000_0013);

      // Redirect target alignment and PC wrap
      do_reset();
      redirect_to(32'hFFFF_FFFF);
      check("wrap_addr0", o_imem_addr, 32'hFFFF_FFFC);
      mem_auto = 1'b1; i_imem_gnt = 1'b1;
      tick(); check("wrap_acc", last_acc_addr, 32'hFFFF_FFFC); check("wrap_addr1", o_imem_addr, 32'h0);
      i_imem_gnt = 1'b0;
      tick(); check("wrap_pc", o_pc, 32'hFFFF_FFFC); check("wrap_v", 32'(o_valid), 32'h1);

`ifdef FETCH_JAL_PREDICT_EN
      // JAL predecode: target taken, sequential successor dropped
      do_reset();
      jal_mode = 1'b1;
      redirect_to(32'h20);
      mem_auto = 1'b1; i_imem_gnt = 1'b1;
      tick(); check("jal_acc0", last_acc_addr, 32'h20);
      tick(); check("jal_addr", o_imem_addr, 32'h120); check("jal_pc", o_pc, 32'h20);
      check("jal_inst", o_inst, 32'h1000_006F);
      tick(); check("jal_acc1", last_acc_addr, 32'h120); check("jal_drop", 32'(o_valid), 32'h0);
      tick(); check("jal_v", 32'(o_valid), 32'h1); check("jal_tpc", o_pc, 32'h120);
      i_imem_gnt = 1'b0; jal_mode = 1'b0;
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] SHALL be zero.
REQ-002 BUF_DEPTH, 2, fetch buffer entries and maximum in-flight credit; legal values 2..4.
REQ-003 i_clk  in  1  clock; all state SHALL update on the rising edge.
REQ-004 i_reset  in  1  reset, asynchronous, active-low.
REQ-005 i_stall  in  1  downstream hold: 1 = IF/ID not accepting.
REQ-006 i_redirect  in  1  taken branch/jump from a later stage.
REQ-007 i_redirect_pc  in  32  redirect target; bits [1:0] ignored, forced to 0.
REQ-008 o_imem_req  out  1  instruction-memory request.
REQ-009 o_imem_addr  out  32  word-aligned request address.
REQ-010 i_imem_gnt  in  1  memory accepts request this cycle.
REQ-011 i_imem_rvalid  in  1  read data valid; responses return in request order, latency >= 1.
REQ-012 i_imem_rdata  in  32  instruction word.
REQ-013 o_valid  out  1  o_pc/o_inst hold a valid fetched instruction.
REQ-014 o_pc  out  32  PC of the head instruction.
REQ-015 o_inst  out  32  head instruction; 32'h13 (NOP) whenever o_valid=0.

Function
REQ-016 The fetch PC register (pc_q) SHALL drive o_imem_addr directly.
REQ-017 o_imem_req SHALL be 1 iff !i_redirect and (outstanding + buffer occupancy) < BUF_DEPTH.
REQ-018 A request SHALL be accepted when o_imem_req && i_imem_gnt; pc_q SHALL then advance by 4 (mod 2^32, wrap from 32'hFFFF_FFFC to 0), and outstanding SHALL increment.
REQ-019 o_imem_addr MAY change while req=1 and gnt=0 only on redirect; otherwise it SHALL be held.
REQ-020 Each i_imem_rvalid SHALL decrement outstanding; a response with discard count > 0 SHALL be dropped and SHALL decrement discard; otherwise {PC, data} SHALL be written to the buffer tail.
REQ-021 The buffer head SHALL be popped when o_valid && !i_stall; simultaneous push and pop SHALL be supported, including when the buffer is full.
REQ-022 A response arriving into an empty buffer SHALL appear on o_valid the following cycle (1-cycle response-to-output latency).
REQ-023 On i_redirect: pc_q <= i_redirect_pc; buffer cleared; discard <= outstanding after this cycle's rvalid is accounted for; a same-cycle rvalid SHALL be dropped.
REQ-024 i_redirect SHALL take priority over i_stall, over push, and over pop.
REQ-025 Back-to-back redirects SHALL each reload pc_q; discard SHALL never exceed BUF_DEPTH.
REQ-026 i_imem_rvalid with outstanding == 0 is illegal; the block SHALL ignore it.

Reset
REQ-027 On i_reset=0: pc_q = RESET_PC; outstanding = 0; discard = 0; buffer empty; o_valid = 0; o_pc = 0; o_inst = 32'h13; o_imem_req = 0 while reset is asserted.
REQ-028 Reset asserted mid-transaction SHALL abandon all in-flight requests; no response SHALL reach the buffer until a new request is issued after reset release.

Configuration
REQ-029 Macro FETCH_JAL_PREDICT_EN.
- Defined: a non-dropped response with opcode 7'b1101111 (JAL) SHALL be pushed normally, and pc_q SHALL be set to its PC + sign-extended J-immediate the same cycle. This is an internal redirect: discard is set to the remaining outstanding count and the buffer is not cleared. An external i_redirect in the same cycle SHALL win.
- Undefined: no predecode logic; JAL is fetched sequentially.

Structure
REQ-030 The shared package pipeline_pkg SHALL hold NOP_INST (32'h13), OPC_JAL, and the fetch-entry struct {pc, inst}.
REQ-031 The buffer SHALL be the sub-module fetch_buf: a parameterised circular FIFO with push, pop, clear, full, empty and count.

Verification
REQ-032 Reset, then gnt=1 and 1-cycle latency, i_stall=0 -> addresses 0x0, 0x4, 0x8 issued back-to-back; o_pc sequence 0x0, 0x4, 0x8 with o_valid held at 1.
REQ-033 i_stall=1 for 5 cycles with BUF_DEPTH=2 -> at most 2 requests beyond the head; o_pc/o_inst stable; no entry lost after release.
REQ-034 Two requests outstanding (0x10, 0x14), redirect to 0x200 in the same cycle as the 0x10 response -> both responses dropped; next o_valid shows o_pc=0x200.
REQ-035 gnt held 0 for 3 cycles at 0x40 -> o_imem_addr stays 0x40, o_valid=0; after gnt, 0x40 delivered once.
REQ-036 Reset asserted with 2 outstanding; release; stale rvalid returned -> ignored; o_valid=0 until a fresh response arrives.
REQ-037 FETCH_JAL_PREDICT_EN defined, JAL imm=+0x100 at 0x20 -> next granted address 0x120; the 0x24 response is dropped.
